// File: rtl/reaction_timer_core.sv
// Reaction-time game engine: random arm delay, BCD response timer, false-start
// and timeout detection, and a clearable best score.
module reaction_timer_core #(
  parameter int CLK_HZ     = 50000000,
  parameter int TICK_HZ    = 1000,
  parameter int NUM_DIGITS = 4,
  parameter int MIN_DELAY  = 500,
  parameter int RAND_BITS  = 11,
  parameter int LED_COUNT  = 10
) (
  input  logic                    MAX10_CLK1_50,
  input  logic                    rst_n,
  input  logic                    start_n,
  input  logic                    stop_n,
  input  logic                    show_hi,
  input  logic                    clear_hi,
  output logic [4*NUM_DIGITS-1:0] disp_bcd,
  output logic [LED_COUNT-1:0]    go_leds,
  output logic                    false_start,
  output logic                    new_record,
  output logic                    timeout,
  output logic [2:0]              state_o
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int DIV_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DLY_W    = $clog2(MIN_DELAY + (1 << RAND_BITS) + 1);
  localparam int BCD_W    = 4 * NUM_DIGITS;
  localparam logic [BCD_W-1:0] ALL_NINES = {NUM_DIGITS{4'h9}};

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_GO     = 3'd2,
    S_RESULT = 3'd3,
    S_FAULT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic               start_q, stop_q;
  logic [15:0]        lfsr_q;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [DLY_W-1:0]   delay_q, delay_d;
  logic [BCD_W-1:0]   time_q, time_d;
  logic [BCD_W-1:0]   hi_q, hi_d;
  logic               new_record_q, new_record_d;
  logic               timeout_q, timeout_d;
  logic               entry_q, entry_d;

  logic               start_p, stop_p, tick, lfsr_fb, do_arm;
  logic [BCD_W-1:0]   time_inc;
  logic [NUM_DIGITS:0] carry;

  assign start_p = start_q & ~start_n;
  assign stop_p  = stop_q & ~stop_n;
  assign tick    = (div_q == DIV_W'(TICK_DIV - 1));
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  // Ripple BCD increment; carry[NUM_DIGITS] means the count is already all 9s.
  assign carry[0] = 1'b1;
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_bcd
      logic [3:0] dig;
      assign dig = time_q[4*gi +: 4];
      assign time_inc[4*gi +: 4] = carry[gi] ? ((dig == 4'd9) ? 4'd0 : dig + 4'd1) : dig;
      assign carry[gi+1] = carry[gi] & (dig == 4'd9);
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    div_d        = tick ? '0 : div_q + DIV_W'(1);
    delay_d      = delay_q;
    time_d       = time_q;
    hi_d         = hi_q;
    new_record_d = new_record_q;
    timeout_d    = timeout_q;
    entry_d      = 1'b0;
    do_arm       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start_p) do_arm = 1'b1;
      end
      S_ARM: begin
        if (stop_p) begin
          state_d = S_FAULT;
        end else if (tick) begin
          if (delay_q <= DLY_W'(1)) begin
            state_d = S_GO;
            div_d   = '0;
            delay_d = '0;
          end else begin
            delay_d = delay_q - DLY_W'(1);
          end
        end
      end
      S_GO: begin
        if (stop_p) begin
          state_d = S_RESULT;
          entry_d = 1'b1;
        end else if (tick) begin
          if (carry[NUM_DIGITS]) begin
            timeout_d = 1'b1;
            state_d   = S_RESULT;
            entry_d   = 1'b1;
          end else begin
            time_d = time_inc;
          end
        end
      end
      S_RESULT: begin
        if (entry_q && (time_q < hi_q)) begin
          hi_d         = time_q;
          new_record_d = 1'b1;
        end
        if (start_p) begin
          do_arm = 1'b1;
        end else if (stop_p) begin
          state_d      = S_IDLE;
          new_record_d = 1'b0;
          timeout_d    = 1'b0;
        end
      end
      S_FAULT: begin
        if (start_p) begin
          do_arm = 1'b1;
        end else if (stop_p) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (do_arm) begin
      state_d      = S_ARM;
      delay_d      = DLY_W'(MIN_DELAY) + DLY_W'(lfsr_q[RAND_BITS-1:0]);
      time_d       = '0;
      div_d        = '0;
      new_record_d = 1'b0;
      timeout_d    = 1'b0;
    end

    // The record comparison owns the high score during the RESULT entry cycle.
    if (clear_hi && !entry_q) hi_d = ALL_NINES;
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      start_q      <= 1'b1;
      stop_q       <= 1'b1;
      lfsr_q       <= 16'hACE1;
      div_q        <= '0;
      delay_q      <= '0;
      time_q       <= '0;
      hi_q         <= ALL_NINES;
      new_record_q <= 1'b0;
      timeout_q    <= 1'b0;
      entry_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_q      <= start_n;
      stop_q       <= stop_n;
      lfsr_q       <= {lfsr_q[14:0], lfsr_fb};
      div_q        <= div_d;
      delay_q      <= delay_d;
      time_q       <= time_d;
      hi_q         <= hi_d;
      new_record_q <= new_record_d;
      timeout_q    <= timeout_d;
      entry_q      <= entry_d;
    end
  end

  always_comb begin
    unique case (state_q)
      S_IDLE:  disp_bcd = show_hi ? hi_q : time_q;
      S_FAULT: disp_bcd = '1;
      default: disp_bcd = time_q;
    endcase
  end

  assign go_leds     = (state_q == S_GO) ? '1 : '0;
  assign false_start = (state_q == S_FAULT);
  assign new_record  = new_record_q & (state_q == S_RESULT);
  assign timeout     = timeout_q & (state_q == S_RESULT);
  assign state_o     = state_q;

endmodule

// File: tb/tb_reaction_timer_core.sv
// Directed bench for reaction_timer_core: a table of game rounds on a TICK_DIV=10
// instance, hand sequences for false starts/reset/clear, and a TICK_DIV=2 instance for timeout.
module tb_reaction_timer_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start_n = 1'b1, stop_n = 1'b1, show_hi = 1'b0, clear_hi = 1'b0;
  logic [15:0] disp_bcd;
  logic [9:0]  go_leds;
  logic        false_start, new_record, timeout;
  logic [2:0]  state_o;

  logic        start2_n = 1'b1, stop2_n = 1'b1, show_hi2 = 1'b0, clear_hi2 = 1'b0;
  logic [15:0] disp2;
  logic [9:0]  leds2;
  logic        fs2, nr2, to2;
  logic [2:0]  st2;

  reaction_timer_core #(.CLK_HZ(10000), .TICK_HZ(1000), .NUM_DIGITS(4), .MIN_DELAY(5),
                        .RAND_BITS(3), .LED_COUNT(10)) u_dut (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .start_n(start_n), .stop_n(stop_n),
    .show_hi(show_hi), .clear_hi(clear_hi), .disp_bcd(disp_bcd), .go_leds(go_leds),
    .false_start(false_start), .new_record(new_record), .timeout(timeout), .state_o(state_o)
  );

  reaction_timer_core #(.CLK_HZ(2000), .TICK_HZ(1000), .NUM_DIGITS(4), .MIN_DELAY(5),
                        .RAND_BITS(3), .LED_COUNT(10)) u_dut_fast (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .start_n(start2_n), .stop_n(stop2_n),
    .show_hi(show_hi2), .clear_hi(clear_hi2), .disp_bcd(disp2), .go_leds(leds2),
    .false_start(fs2), .new_record(nr2), .timeout(to2), .state_o(st2)
  );

  // Reference LFSR: Fibonacci x^16+x^14+x^13+x^11, seed ACE1, steps every clock.
  logic [15:0] ref_lfsr;
  always @(posedge clk) begin
    if (!rst_n) ref_lfsr <= 16'hACE1;
    else        ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  typedef struct {
    int          ticks;
    logic [15:0] exp_time;
    logic        exp_rec;
    logic [15:0] exp_hi;
  } round_t;

  round_t rounds[4];
  int n_vec = 0;
  int n_err = 0;
  int exp_delay;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press_start1();
    @(negedge clk);
    start_n = 1'b0;
    exp_delay = 5 + int'(ref_lfsr[2:0]);
    @(negedge clk);
    start_n = 1'b1;
  endtask

  task automatic press_stop1();
    @(negedge clk);
    stop_n = 1'b0;
    @(negedge clk);
    stop_n = 1'b1;
  endtask

  task automatic wait_go1(input string tag);
    int n = 0;
    while (state_o !== 3'd2 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, " go_delay"}, n, exp_delay * 10);
    check({tag, " go_leds"}, go_leds, 10'h3FF);
  endtask

  task automatic run_round(input round_t r);
    press_start1();
    check("arm_state", state_o, 3'd1);
    wait_go1("round");
    repeat (r.ticks * 10) @(negedge clk);
    stop_n = 1'b0;
    @(negedge clk);
    stop_n = 1'b1;
    check("result_state", state_o, 3'd3);
    @(negedge clk);
    check("result_time", disp_bcd, r.exp_time);
    check("new_record", new_record, r.exp_rec);
    check("no_timeout", timeout, 1'b0);
    press_stop1();
    check("back_idle", state_o, 3'd0);
    show_hi = 1'b1;
    #1;
    check("hi_score", disp_bcd, r.exp_hi);
    show_hi = 1'b0;
    $display("round ticks=%0d delay=%0d time=%h rec=%b hi=%h", r.ticks, exp_delay,
             r.exp_time, r.exp_rec, r.exp_hi);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int d2;
    rounds[0] = '{237, 16'h0237, 1'b1, 16'h0237};
    rounds[1] = '{300, 16'h0300, 1'b0, 16'h0237};
    rounds[2] = '{237, 16'h0237, 1'b0, 16'h0237};
    rounds[3] = '{0,   16'h0000, 1'b1, 16'h0000};

    repeat (3) @(negedge clk);
    check("rst_state", state_o, 3'd0);
    check("rst_leds", go_leds, 10'h000);
    check("rst_disp", disp_bcd, 16'h0000);
    check("rst_flags", {false_start, new_record, timeout}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);
    show_hi = 1'b1;
    #1;
    check("rst_hi", disp_bcd, 16'h9999);
    show_hi = 1'b0;
    $display("reset done");

    for (int i = 0; i < 4; i++) run_round(rounds[i]);

    // False start, FAULT exits, re-arm from FAULT.
    press_start1();
    repeat (5) @(negedge clk);
    stop_n = 1'b0;
    @(negedge clk);
    stop_n = 1'b1;
    check("fault_state", state_o, 3'd4);
    check("fault_flag", false_start, 1'b1);
    check("fault_disp", disp_bcd, 16'hFFFF);
    check("fault_leds", go_leds, 10'h000);
    press_stop1();
    check("fault_to_idle", state_o, 3'd0);
    check("fault_flag_clr", false_start, 1'b0);
    press_start1();
    press_stop1();
    check("fault_again", state_o, 3'd4);
    press_start1();
    check("fault_rearm", state_o, 3'd1);
    // Stop lands on the very edge where the delay expires.
    repeat (exp_delay * 10 - 1) @(negedge clk);
    stop_n = 1'b0;
    @(negedge clk);
    stop_n = 1'b1;
    check("stop_at_expiry", state_o, 3'd4);
    press_stop1();
    $display("false start sequence done");

    // Reset while in GO.
    press_start1();
    wait_go1("rst_go");
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_go_state", state_o, 3'd0);
    check("rst_go_leds", go_leds, 10'h000);
    check("rst_go_disp", disp_bcd, 16'h0000);
    rst_n = 1'b1;
    show_hi = 1'b1;
    #1;
    check("rst_go_hi", disp_bcd, 16'h9999);
    show_hi = 1'b0;
    $display("reset in GO done");

    // Record then clear_hi.
    run_round('{5, 16'h0005, 1'b1, 16'h0005});
    @(negedge clk);
    clear_hi = 1'b1;
    @(negedge clk);
    clear_hi = 1'b0;
    show_hi = 1'b1;
    #1;
    check("clear_hi", disp_bcd, 16'h9999);
    show_hi = 1'b0;
    $display("clear_hi done");

    // Fast instance: set a record, then let the counter saturate.
    @(negedge clk);
    start2_n = 1'b0;
    d2 = 5 + int'(ref_lfsr[2:0]);
    @(negedge clk);
    start2_n = 1'b1;
    check("f_arm", st2, 3'd1);
    n = 0;
    while (st2 !== 3'd2 && n < 200) begin @(negedge clk); n++; end
    check("f_go_delay", n, d2 * 2);
    repeat (24) @(negedge clk);
    stop2_n = 1'b0;
    @(negedge clk);
    stop2_n = 1'b1;
    @(negedge clk);
    check("f_time", disp2, 16'h0012);
    check("f_rec", nr2, 1'b1);
    @(negedge clk); stop2_n = 1'b0; @(negedge clk); stop2_n = 1'b1;
    check("f_idle", st2, 3'd0);
    $display("fast round time=0012");

    @(negedge clk);
    start2_n = 1'b0;
    d2 = 5 + int'(ref_lfsr[2:0]);
    @(negedge clk);
    start2_n = 1'b1;
    n = 0;
    while (st2 !== 3'd2 && n < 200) begin @(negedge clk); n++; end
    check("f_go_delay2", n, d2 * 2);
    n = 0;
    while (st2 !== 3'd3 && n < 25000) begin @(negedge clk); n++; end
    @(negedge clk);
    check("to_state", st2, 3'd3);
    check("to_disp", disp2, 16'h9999);
    check("to_flag", to2, 1'b1);
    check("to_no_rec", nr2, 1'b0);
    check("to_leds", leds2, 10'h000);
    repeat (5) @(negedge clk);
    check("to_hold", disp2, 16'h9999);
    @(negedge clk); start2_n = 1'b0; @(negedge clk); start2_n = 1'b1;
    check("to_rearm", st2, 3'd1);
    check("to_clr", to2, 1'b0);
    @(negedge clk); stop2_n = 1'b0; @(negedge clk); stop2_n = 1'b1;
    check("to_fault", st2, 3'd4);
    @(negedge clk); stop2_n = 1'b0; @(negedge clk); stop2_n = 1'b1;
    show_hi2 = 1'b1;
    #1;
    check("to_hi_kept", disp2, 16'h0012);
    show_hi2 = 1'b0;
    $display("timeout round time=9999");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
